// File: rtl/block_config_pkg.sv
// Shared state encoding and sizing helpers for the block configuration loader.
// Build option BLOCK_CONFIG_PARITY_EN appends one even-parity word to every frame.
package block_config_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      LOAD,
      HOLD,
      DONE
   } state_t;

   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int DEF_ADDR_BITS  = 4;
   localparam int DEF_WORD_BITS  = 8;
   localparam int DEF_NUM_BLOCKS = 8;
   localparam int DEF_CEN_CYCLES = 2;

   localparam int WORDS_PER_FRAME = (2 ** DEF_ADDR_BITS) / DEF_WORD_BITS;
   localparam int BLK_IDX_BITS    = idx_bits(DEF_NUM_BLOCKS);

`ifdef BLOCK_CONFIG_PARITY_EN
   localparam int PARITY_WORDS = 1;
`else
   localparam int PARITY_WORDS = 0;
`endif

endpackage

// File: rtl/block_config_loader_if.sv
// Valid/ready word stream from the fabric configuration port into the loader.
interface block_config_loader_if
   import block_config_pkg::*;
#(
   parameter int WORD_BITS = DEF_WORD_BITS
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [WORD_BITS-1:0] cfg_data;

   modport master (output cfg_valid, output cfg_data, input cfg_ready);
   modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/block_config_frame_packer.sv
// Packs incoming words LSB-first into the frame register that drives config_in.
// Words past the frame (the parity word, when enabled) are counted but not stored.
module block_config_frame_packer
   import block_config_pkg::*;
#(
   parameter int WORD_BITS   = DEF_WORD_BITS,
   parameter int MEM_SIZE    = 2 ** DEF_ADDR_BITS,
   parameter int TOTAL_WORDS = WORDS_PER_FRAME + PARITY_WORDS
) (
   input  logic                 cclk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 accept,
   input  logic [WORD_BITS-1:0] word,
   output logic [MEM_SIZE-1:0]  frame,
   output logic                 last_word
);
   localparam int FRAME_WORDS = MEM_SIZE / WORD_BITS;
   localparam int CNT_BITS    = $clog2(TOTAL_WORDS + 1);

   logic [CNT_BITS-1:0] word_cnt;

   always_ff @(posedge cclk) begin
      if (rst) begin
         word_cnt <= '0;
         frame    <= '0;
      end else begin
         if (clear) begin
            word_cnt <= '0;
         end else if (accept) begin
            word_cnt <= word_cnt + CNT_BITS'(1);
         end
         if (accept) begin
            for (int k = 0; k < FRAME_WORDS; k++) begin
               if (word_cnt == CNT_BITS'(k)) begin
                  frame[k*WORD_BITS +: WORD_BITS] <= word;
               end
            end
         end
      end
   end

   assign last_word = (word_cnt == CNT_BITS'(TOTAL_WORDS - 1));

endmodule

// File: rtl/block_config_loader.sv
// Loads NUM_BLOCKS latch blocks over a shared config_in bus with a one-hot cen pulse each.
// Optional build macro: BLOCK_CONFIG_PARITY_EN (per-frame even-parity word, sticky error).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start
// COLLECT | accepting words for the current block's frame
// LOAD    | cen[blk_idx] high, CEN_CYCLES cycles (down-counter)
// HOLD    | cen low, config_in stable so the latches close on settled data
// DONE    | one-cycle done pulse, back to IDLE
module block_config_loader
   import block_config_pkg::*;
#(
   parameter int ADDR_BITS  = DEF_ADDR_BITS,
   parameter int MEM_SIZE   = 2 ** ADDR_BITS,
   parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
   parameter int WORD_BITS  = DEF_WORD_BITS,
   parameter int CEN_CYCLES = DEF_CEN_CYCLES,
   localparam int IDX_BITS  = idx_bits(NUM_BLOCKS)
) (
   input  logic                  cclk,
   input  logic                  rst,
   input  logic                  start,
   block_config_loader_if.slave  cfg,
   output logic [MEM_SIZE-1:0]   config_in,
   output logic [NUM_BLOCKS-1:0] cen,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [IDX_BITS-1:0]   blk_idx
);
   localparam int FRAME_WORDS = MEM_SIZE / WORD_BITS;
   localparam int TOTAL_WORDS = FRAME_WORDS + PARITY_WORDS;
   localparam int CEN_BITS    = idx_bits(CEN_CYCLES);
   localparam logic [CEN_BITS-1:0] CEN_LOAD = CEN_BITS'(CEN_CYCLES - 1);
   localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(NUM_BLOCKS - 1);

   state_t                state_q;
   state_t                state_d;
   logic [IDX_BITS-1:0]   blk_idx_d;
   logic [CEN_BITS-1:0]   cen_cnt_q;
   logic [CEN_BITS-1:0]   cen_cnt_d;
   logic [NUM_BLOCKS-1:0] cen_d;
   logic                  ready;
   logic                  accept;
   logic                  last_word;
   logic                  parity_bad;

   assign ready         = (state_q == COLLECT);
   assign cfg.cfg_ready = ready;
   assign accept        = cfg.cfg_valid && ready;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);

   block_config_frame_packer #(
      .WORD_BITS   (WORD_BITS),
      .MEM_SIZE    (MEM_SIZE),
      .TOTAL_WORDS (TOTAL_WORDS)
   ) u_packer (
      .cclk      (cclk),
      .rst       (rst),
      .clear     (!ready),
      .accept    (accept),
      .word      (cfg.cfg_data),
      .frame     (config_in),
      .last_word (last_word)
   );

`ifdef BLOCK_CONFIG_PARITY_EN
   logic err_q;

   // The parity word arrives after the whole frame is stored, so check it as it transfers.
   assign parity_bad = cfg.cfg_data[0] ^ (^config_in);

   always_ff @(posedge cclk) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (accept && last_word && parity_bad) begin
         err_q <= 1'b1;
      end
   end

   assign error = err_q;
`else
   assign parity_bad = 1'b0;
   assign error      = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      blk_idx_d = blk_idx;
      cen_cnt_d = cen_cnt_q;
      cen_d     = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = COLLECT;
               blk_idx_d = '0;
            end
         end
         COLLECT: begin
            if (accept && last_word) begin
               if (parity_bad) begin
                  state_d = DONE;
               end else begin
                  state_d   = LOAD;
                  cen_cnt_d = CEN_LOAD;
               end
            end
         end
         LOAD: begin
            if (cen_cnt_q == '0) begin
               state_d = HOLD;
            end else begin
               cen_cnt_d = cen_cnt_q - CEN_BITS'(1);
            end
         end
         HOLD: begin
            if (blk_idx == IDX_LAST) begin
               state_d = DONE;
            end else begin
               state_d   = COLLECT;
               blk_idx_d = blk_idx + IDX_BITS'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // cen is registered from the next state so it tracks LOAD exactly, never multi-hot.
      for (int b = 0; b < NUM_BLOCKS; b++) begin
         if (state_d == LOAD && blk_idx_d == IDX_BITS'(b)) begin
            cen_d[b] = 1'b1;
         end
      end
   end

   always_ff @(posedge cclk) begin
      if (rst) begin
         state_q   <= IDLE;
         blk_idx   <= '0;
         cen_cnt_q <= '0;
         cen       <= '0;
      end else begin
         state_q   <= state_d;
         blk_idx   <= blk_idx_d;
         cen_cnt_q <= cen_cnt_d;
         cen       <= cen_d;
      end
   end

endmodule

// File: tb/tb_block_config_loader.sv
// Directed bench: default 8-block loader plus a 1-block, 16-bit-word, 1-cycle-cen instance.
module tb_block_config_loader;
   import block_config_pkg::*;

   localparam int NB   = 8;
   localparam int CEN  = 2;
   localparam int TOT  = 2 + PARITY_WORDS;
   localparam int TOT1 = 1 + PARITY_WORDS;

   logic cclk = 1'b0;
   always #5 cclk = ~cclk;

   logic        rst;
   logic        start;
   logic        start1;
   logic [15:0] config_in;
   logic [7:0]  cen;
   logic        busy;
   logic        done;
   logic        error;
   logic [2:0]  blk_idx;
   logic [15:0] config_in1;
   logic [0:0]  cen1;
   logic        busy1;
   logic        done1;
   logic        error1;
   logic [0:0]  blk_idx1;

   int n_checks;
   int n_fail;

   block_config_loader_if #(.WORD_BITS(8))  cfg_if ();
   block_config_loader_if #(.WORD_BITS(16)) cfg1_if ();

   block_config_loader u_dut (
      .cclk      (cclk),
      .rst       (rst),
      .start     (start),
      .cfg       (cfg_if),
      .config_in (config_in),
      .cen       (cen),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .blk_idx   (blk_idx)
   );

   block_config_loader #(
      .ADDR_BITS  (4),
      .NUM_BLOCKS (1),
      .WORD_BITS  (16),
      .CEN_CYCLES (1)
   ) u_dut1 (
      .cclk      (cclk),
      .rst       (rst),
      .start     (start1),
      .cfg       (cfg1_if),
      .config_in (config_in1),
      .cen       (cen1),
      .busy      (busy1),
      .done      (done1),
      .error     (error1),
      .blk_idx   (blk_idx1)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Block b's frame is {word 2b+1, word 2b} with words numbered 0,1,2,...
   function automatic logic [15:0] frame_of(input int b);
      return {8'(2 * b + 1), 8'(2 * b)};
   endfunction

   function automatic logic [7:0] word_at(input int b, input int k);
      logic [15:0] fr;
      fr = frame_of(b);
      if (k == 0) return fr[7:0];
      if (k == 1) return fr[15:8];
      return {7'd0, ^fr};
   endfunction

   // Full pass on the 8-block instance. Start is driven for the edge right after entry,
   // so observation index cyc counts edges since start was accepted.
   task automatic run_pass(input int pct, input bit poke_start, input int abort_blk);
      int src_blk, src_k, cyc, done_cyc, n_done, eb, stop_cyc;
      int cen_seen [NB];
      logic [NB-1:0] exp_cen;
      bit go;
      src_blk = 0; src_k = 0; cyc = -1; done_cyc = -1; n_done = 0;
      stop_cyc = 3000; go = 1'b1;
      foreach (cen_seen[i]) cen_seen[i] = 0;
      start = 1'b1;
      cfg_if.cfg_valid = 1'b0;
      while (go) begin
         @(negedge cclk);
         cyc++;
         start = 1'b0;
         if (cyc == 0) chk("busy_after_start", 32'(busy), 32'(1));
         if (cyc == 0 && poke_start) start = 1'b1;
         eb = src_blk - 1;
         if (cen != '0) begin
            exp_cen = (eb >= 0) ? (NB'(1) << eb) : '0;
            chk("cen_select", 32'(cen), 32'(exp_cen));
            chk("frame_at_cen", 32'(config_in), 32'(frame_of(eb)));
            chk("blk_idx_at_cen", 32'(blk_idx), 32'(eb));
            if (eb >= 0 && eb < NB) cen_seen[eb]++;
            if (eb == abort_blk) begin
               rst = 1'b1;
               @(negedge cclk);
               chk("rst_cen", 32'(cen), 32'(0));
               chk("rst_busy", 32'(busy), 32'(0));
               chk("rst_blk_idx", 32'(blk_idx), 32'(0));
               chk("rst_ready", 32'(cfg_if.cfg_ready), 32'(0));
               rst = 1'b0;
               cfg_if.cfg_valid = 1'b0;
               return;
            end
         end
         if (done) begin
            n_done++;
            if (done_cyc < 0) begin
               done_cyc = cyc;
               stop_cyc = cyc + 6;
            end
            if (poke_start) start = 1'b1;
         end
         if (src_blk < NB && $urandom_range(99) < pct) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_data  = word_at(src_blk, src_k);
            if (cfg_if.cfg_ready) begin
               src_k++;
               if (src_k == TOT) begin
                  src_k = 0;
                  src_blk++;
               end
            end
         end else begin
            cfg_if.cfg_valid = 1'b0;
            cfg_if.cfg_data  = 8'($urandom);
         end
         if (cyc >= stop_cyc) go = 1'b0;
      end
      chk("done_seen", 32'(done_cyc >= 0), 32'(1));
      chk("done_count", 32'(n_done), 32'(1));
      if (pct >= 100) chk("done_latency", 32'(done_cyc), 32'(NB * (TOT + CEN + 1)));
      for (int b = 0; b < NB; b++) chk("cen_width", 32'(cen_seen[b]), 32'(CEN));
      chk("words_used", 32'(src_blk), 32'(NB));
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_cen", 32'(cen), 32'(0));
   endtask

   initial begin
      int k1, done1_cyc, cen1_n;
      logic [15:0] w1;
`ifdef BLOCK_CONFIG_PARITY_EN
      int kp, pe_done, pe_cen;
`endif
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; start = 1'b0; start1 = 1'b0;
      cfg_if.cfg_valid  = 1'b0; cfg_if.cfg_data  = '0;
      cfg1_if.cfg_valid = 1'b0; cfg1_if.cfg_data = '0;
      repeat (3) @(negedge cclk);

      chk("rst_state_cen", 32'(cen), 32'(0));
      chk("rst_state_config_in", 32'(config_in), 32'(0));
      chk("rst_state_ready", 32'(cfg_if.cfg_ready), 32'(0));
      chk("rst_state_busy", 32'(busy), 32'(0));
      chk("rst_state_done", 32'(done), 32'(0));
      chk("rst_state_error", 32'(error), 32'(0));
      chk("rst_state_blk_idx", 32'(blk_idx), 32'(0));
      chk("rst_state_d1_cen", 32'(cen1), 32'(0));
      chk("rst_state_d1_busy", 32'(busy1), 32'(0));
      rst = 1'b0;
      @(negedge cclk);

      run_pass(100, 1'b0, -1);
      run_pass(30, 1'b0, -1);
      run_pass(100, 1'b1, -1);
      run_pass(100, 1'b0, 3);
      run_pass(100, 1'b0, -1);
      chk("no_error_after_passes", 32'(error), 32'(0));

      // Single-block, single-word-frame instance.
      w1 = 16'hA5C3;
      k1 = 0; done1_cyc = -1; cen1_n = 0;
      start1 = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge cclk);
         start1 = 1'b0;
         if (cen1 != '0) begin
            cen1_n++;
            chk("d1_frame_at_cen", 32'(config_in1), 32'(w1));
         end
         if (done1 && done1_cyc < 0) done1_cyc = c;
         if (k1 < TOT1) begin
            cfg1_if.cfg_valid = 1'b1;
            cfg1_if.cfg_data  = (k1 == 0) ? w1 : {15'd0, ^w1};
            if (cfg1_if.cfg_ready) k1++;
         end else begin
            cfg1_if.cfg_valid = 1'b0;
         end
      end
      chk("d1_cen_width", 32'(cen1_n), 32'(1));
      chk("d1_done_latency", 32'(done1_cyc), 32'(TOT1 + 2));
      chk("d1_busy_end", 32'(busy1), 32'(0));
      chk("d1_error", 32'(error1), 32'(0));

`ifdef BLOCK_CONFIG_PARITY_EN
      // Frame 0x0001 with parity bit 0: odd frame, so the parity word is wrong.
      kp = 0; pe_done = -1; pe_cen = 0;
      start = 1'b1;
      cfg_if.cfg_valid = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge cclk);
         start = 1'b0;
         if (cen != '0) pe_cen++;
         if (done && pe_done < 0) pe_done = c;
         if (kp < 3) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_data  = (kp == 0) ? 8'h01 : 8'h00;
            if (cfg_if.cfg_ready) kp++;
         end else begin
            cfg_if.cfg_valid = 1'b0;
         end
      end
      chk("par_cen_quiet", 32'(pe_cen), 32'(0));
      chk("par_done_latency", 32'(pe_done), 32'(3));
      chk("par_error_sticky", 32'(error), 32'(1));
      chk("par_busy_end", 32'(busy), 32'(0));
      rst = 1'b1;
      @(negedge cclk);
      rst = 1'b0;
      chk("par_error_cleared", 32'(error), 32'(0));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
